// File: rtl/dram_responder.sv
// Responder end of the core memory bus: single outstanding request, modelled DRAM latency,
// byte-enabled 64-bit backing store, and tagged responses with misalignment/range errors.
module dram_responder #(
    parameter int MEM_WORDS     = 4096,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2,
    parameter int TAG_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [20:0]      req_addr,
    input  logic [63:0]      req_wdata,
    input  logic [7:0]       req_byte_en,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [63:0]      resp_rdata,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_is_write,
    output logic             resp_error
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    logic [3:0]       r_cnt;
    logic             r_write;
    logic [20:0]      r_addr;
    logic [63:0]      r_wdata;
    logic [7:0]       r_byteEn;
    logic [TAG_W-1:0] r_tag;

    logic [63:0]      r_mem [MEM_WORDS];

    logic [63:0]      r_respRdata;
    logic [TAG_W-1:0] r_respTag;
    logic             r_respIsWrite;
    logic             r_respError;

    logic             w_accept;
    logic             w_access;
    logic             w_err;
    logic             w_commit;
    logic [31:0]      w_wordAddr;
    logic [IDX_W-1:0] w_idx;

    assign req_ready  = (r_state == IDLE) && !reset;
    assign w_accept   = req_valid && req_ready;
    assign w_access   = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_wordAddr = {14'd0, r_addr[20:3]};
    assign w_err      = (r_addr[2:0] != 3'b000) || (w_wordAddr >= 32'(MEM_WORDS));
    assign w_idx      = r_addr[3 +: IDX_W];
    assign w_commit   = w_access && r_write && !w_err && !reset;

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_stateNext = WAIT;
            WAIT:    if (r_cnt == 4'd0) w_stateNext = RESPOND;
            RESPOND: if (resp_ready) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Request fields only matter while a request is in flight, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write  <= req_write;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_byteEn <= req_byte_en;
            r_tag    <= req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= 4'd0;
            r_respRdata   <= 64'd0;
            r_respTag     <= '0;
            r_respIsWrite <= 1'b0;
            r_respError   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= req_write ? 4'(WRITE_LATENCY - 1) : 4'(READ_LATENCY - 1);
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_respRdata   <= (r_write || w_err) ? 64'd0 : r_mem[w_idx];
                r_respTag     <= r_tag;
                r_respIsWrite <= r_write;
                r_respError   <= w_err;
            end
        end
    end

    // Backing store survives reset; a write still waiting when reset hits is never committed.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 8; i++) begin
                if (r_byteEn[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign resp_valid    = (r_state == RESPOND);
    assign resp_rdata    = r_respRdata;
    assign resp_tag      = r_respTag;
    assign resp_is_write = r_respIsWrite;
    assign resp_error    = r_respError;

endmodule
